oddr_tx_serializer: RTL



---
 rtl/oddr_tx_serializer_if.sv | 12 +
 rtl/oddr_tx_serializer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/oddr_tx_serializer_if.sv
// Word handshake between the transmit framing logic and the ODDR serializer.
interface oddr_tx_serializer_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_LAST;
  logic             IN_READY;

  modport master (output IN_VALID, output IN_DATA, output IN_LAST, input IN_READY);
  modport slave  (input IN_VALID, input IN_DATA, input IN_LAST, output IN_READY);
endinterface

// File: rtl/oddr_tx_serializer.sv
// Word-to-DDR scheduler: turns WIDTH-bit words into two bits per clock for
// one ODDR primitive. It also owns CE/R/S so the pad idles at IDLE_LEVEL
// between bursts. Every ODDR-facing output comes straight from a flop.
module oddr_tx_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   GAP_CYCLES = 4,
  parameter bit   MSB_FIRST  = 1'b1
) (
  input  logic                  C,
  input  logic                  R_N,
  input  logic                  EN,
  oddr_tx_serializer_if.slave   in_if,
  output logic                  D1,
  output logic                  D2,
  output logic                  CE_OUT,
  output logic                  R_OUT,
  output logic                  S_OUT,
  output logic                  BUSY,
  output logic                  UNDERRUN
);

  localparam int N   = WIDTH / 2;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int SHW = (WIDTH > 2) ? WIDTH - 2 : 1;
  localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SHW-1:0]   shreg_q, shreg_d;
  logic             last_q, last_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             d1_q, d1_d, d2_q, d2_d;
  logic             ce_q, ce_d, r_q, r_d, s_q, s_d;
  logic             underrun_q, underrun_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] word_ord;     // word reordered so the first bit in time is the MSB
  logic [SHW-1:0]   shreg_load;   // remainder after the first pair
  logic [SHW-1:0]   shreg_shift;  // shift register after popping one pair
  logic [1:0]       next_pair;    // {D1, D2} for the following cycle

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_order
    if (MSB_FIRST) begin : g_msb
      assign word_ord[gi] = in_if.IN_DATA[gi];
    end else begin : g_lsb
      assign word_ord[gi] = in_if.IN_DATA[WIDTH-1-gi];
    end
  end

  // A 2-bit word has no remainder, so the shift register is a dummy there.
  if (WIDTH > 2) begin : g_sh
    assign shreg_load = word_ord[WIDTH-3:0];
    assign next_pair  = shreg_q[SHW-1 -: 2];
    if (WIDTH > 4) begin : g_wide
      assign shreg_shift = {shreg_q[SHW-3:0], 2'b00};
    end else begin : g_narrow
      assign shreg_shift = '0;
    end
  end else begin : g_nosh
    assign shreg_load  = '0;
    assign next_pair   = {2{IDLE_LEVEL}};
    assign shreg_shift = shreg_q;
  end

  // Ready: idle takes a word whenever enabled; a running burst only on its final pair.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = EN;
      ST_SHIFT: in_ready = (cnt_q == CNT_MAX) && !last_q && EN;
      default:  in_ready = 1'b0;
    endcase
  end

  assign in_if.IN_READY = in_ready && R_N;
  assign accept         = in_if.IN_VALID && in_ready;

  // Next-state and next-output computation for the IDLE/SHIFT/GAP scheduler.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    gap_d      = gap_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    ce_d       = ce_q;
    r_d        = r_q;
    s_d        = s_q;
    underrun_d = 1'b0;

    if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      d1_d    = word_ord[WIDTH-1];
      d2_d    = word_ord[WIDTH-2];
      shreg_d = shreg_load;
      last_d  = in_if.IN_LAST;
      ce_d    = 1'b1;
      r_d     = 1'b0;
      s_d     = 1'b0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d   = cnt_q + CW'(1);
            d1_d    = next_pair[1];
            d2_d    = next_pair[0];
            shreg_d = shreg_shift;
          end else begin
            // Starved only if the framer still owed us a word and was allowed to send it.
            underrun_d = !last_q && EN;
            d1_d       = IDLE_LEVEL;
            d2_d       = IDLE_LEVEL;
            ce_d       = 1'b0;
            r_d        = !IDLE_LEVEL;
            s_d        = IDLE_LEVEL;
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
              gap_d   = GW'(GAP_CYCLES);
            end
          end
        end
        ST_GAP: begin
          if (gap_q <= GW'(1)) begin
            state_d = ST_IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output flops; reset forces the pad to its idle drive immediately.
  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      gap_q      <= '0;
      d1_q       <= IDLE_LEVEL;
      d2_q       <= IDLE_LEVEL;
      ce_q       <= 1'b0;
      r_q        <= !IDLE_LEVEL;
      s_q        <= IDLE_LEVEL;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      ce_q       <= ce_d;
      r_q        <= r_d;
      s_q        <= s_d;
      underrun_q <= underrun_d;
    end
  end

  assign D1       = d1_q;
  assign D2       = d2_q;
  assign CE_OUT   = ce_q;
  assign R_OUT    = r_q;
  assign S_OUT    = s_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign UNDERRUN = underrun_q;

endmodule
